request_unit_mc: RTL and testbench

//  Multi-channel request unit between the CPU datapath and the memory controller.

---
 rtl/request_unit_mc_pkg.sv | 17 +
 rtl/request_unit_mc_rr_arbiter.sv | 34 +++
 rtl/request_unit_mc.sv | 138 +++++++++++++
 tb/tb_request_unit_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/request_unit_mc_pkg.sv
// Shared types for the multi-channel request unit.
// States, channel limit and index-width helper.
package request_unit_mc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    HALTED
  } rumc_state_t;

  localparam int NCH_MAX = 8;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/request_unit_mc_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr.
// Purely combinational; the pointer lives in the parent.
module rr_arbiter
  import request_unit_mc_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idxW(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // scan ptr..N-1 first, then wrap to 0..ptr-1
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) < ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_unit_mc.sv
// Multi-channel request unit: round-robin dmem arbitration,
// fetch gating, halt drain and a memory watchdog.
module request_unit_mc
  import request_unit_mc_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           iREN,
  input  logic [NCH-1:0] dREN,
  input  logic [NCH-1:0] dWEN,
  input  logic           ihit,
  input  logic           dhit,
  input  logic           halt,
  output logic           imemREN,
  output logic           dmemREN,
  output logic           dmemWEN,
  output logic [NCH-1:0] dgrant,
  output logic [NCH-1:0] dack,
  output logic           pc_wait,
  output logic           halt_out,
  output logic           timeout
);

  localparam int PW = idxW(NCH);
  localparam int WW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC);
  localparam logic [PW-1:0] LAST   = PW'(NCH - 1);

  rumc_state_t    state;
  logic [PW-1:0]  rrPtr;
  logic [PW-1:0]  gIdx;
  logic [NCH-1:0] grantQ;
  logic           haltPend;
  logic [WW-1:0]  wdCnt;
  logic           timeoutQ;

  logic [NCH-1:0] req;
  logic [NCH-1:0] arbGnt;
  logic [PW-1:0]  arbIdx;
  logic           anyReq;
  logic           wSel;
  logic           rSel;

  assign req    = dREN | dWEN;
  assign anyReq = |req;
  assign wSel   = |(dWEN & grantQ);
  assign rSel   = |(dREN & grantQ);

  rr_arbiter #(
    .N  (NCH),
    .PW (PW)
  ) uArb (
    .req (req),
    .ptr (rrPtr),
    .gnt (arbGnt)
  );

  // one-hot grant to channel index
  always_comb begin
    arbIdx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arbGnt[i]) arbIdx = PW'(i);
    end
  end

  // control FSM, rr pointer, halt latch and watchdog
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rrPtr    <= '0;
      gIdx     <= '0;
      grantQ   <= '0;
      haltPend <= 1'b0;
      wdCnt    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      if (halt) haltPend <= 1'b1;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantQ <= arbGnt;
            gIdx   <= arbIdx;
            wdCnt  <= '0;
            state  <= DATA;
          end else if (haltPend) begin
            state <= HALTED;
          end
        end
        DATA: begin
          if (TIMEOUT_CYC > 0 && wdCnt == WD_MAX)
            timeoutQ <= 1'b1;
          if (dhit) begin
            rrPtr  <= (gIdx == LAST) ? '0 : gIdx + 1'b1;
            grantQ <= '0;
            state  <= IDLE;
          end else if (wdCnt != WD_MAX) begin
            wdCnt <= wdCnt + 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // state decode to memory-side and datapath outputs
  always_comb begin
    imemREN  = 1'b0;
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    dgrant   = '0;
    dack     = '0;
    halt_out = 1'b0;
    if (nRST) begin
      case (state)
        IDLE: imemREN = iREN & ~haltPend;
        DATA: begin
          dgrant  = grantQ;
          dmemWEN = wSel;
          dmemREN = rSel & ~wSel;
          if (dhit) dack = grantQ;
        end
        HALTED: halt_out = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_wait = nRST & ((state == DATA)
                         | (state == HALTED)
                         | (imemREN & ~ihit));
  assign timeout = timeoutQ;

endmodule

// File: tb/tb_request_unit_mc.sv
// Bench for request_unit_mc: vector table, corner
// sequences, and random traffic against a reference model.
module tb_request_unit_mc;

  localparam int NCH = 2;
  localparam int TO  = 4;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           iREN;
  logic [NCH-1:0] dREN;
  logic [NCH-1:0] dWEN;
  logic           ihit;
  logic           dhit;
  logic           halt;
  logic           imemREN;
  logic           dmemREN;
  logic           dmemWEN;
  logic [NCH-1:0] dgrant;
  logic [NCH-1:0] dack;
  logic           pc_wait;
  logic           halt_out;
  logic           timeout;

  wire [9:0] outv = {imemREN, dmemREN, dmemWEN, dgrant,
                     dack, pc_wait, halt_out, timeout};

  int nChk  = 0;
  int nFail = 0;

  typedef struct {
    logic       iR;
    logic [1:0] dR;
    logic [1:0] dW;
    logic       ih;
    logic       dh;
    logic       hl;
    logic [9:0] e;
  } vec_t;

  vec_t tv[$];

  request_unit_mc #(
    .NCH         (NCH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .ihit     (ihit),
    .dhit     (dhit),
    .halt     (halt),
    .imemREN  (imemREN),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dgrant   (dgrant),
    .dack     (dack),
    .pc_wait  (pc_wait),
    .halt_out (halt_out),
    .timeout  (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm,
                       input logic [9:0] act,
                       input logic [9:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b required %b (I R W GG AA P H T)",
               nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic iR,
                             input logic [1:0] dR,
                             input logic [1:0] dW,
                             input logic ih, dh, hl,
                             input logic [9:0] e);
    vec_t r;
    r.iR = iR; r.dR = dR; r.dW = dW;
    r.ih = ih; r.dh = dh; r.hl = hl; r.e = e;
    return r;
  endfunction

  task automatic idleIn();
    iREN = 0; dREN = '0; dWEN = '0;
    ihit = 0; dhit = 0; halt = 0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 0;
    iREN = 1; dREN = '1; dWEN = '1;
    ihit = 1; dhit = 1; halt = 0;
    #1 check("reset_outputs", outv, 10'b0);
    @(negedge CLK);
    idleIn();
    nRST = 1;
  endtask

  // reference model state
  int         mOwner, mNext, mMiss;
  bit         mHp, mHalted, mTo;
  logic [1:0] rR, rW;

  initial begin
    nRST = 0;
    idleIn();

    // fetch-only, round robin, write priority, halt drain
    tv.push_back(v(1,2'b00,2'b00,0,0,0,10'b1_0_0_00_00_1_0_0));
    tv.push_back(v(1,2'b00,2'b00,0,0,0,10'b1_0_0_00_00_1_0_0));
    tv.push_back(v(1,2'b00,2'b00,0,0,0,10'b1_0_0_00_00_1_0_0));
    tv.push_back(v(1,2'b00,2'b00,1,0,0,10'b1_0_0_00_00_0_0_0));
    tv.push_back(v(0,2'b00,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0_1_0_01_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0_1_0_01_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,1,0,10'b0_1_0_01_01_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0_1_0_10_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0_1_0_10_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,1,0,10'b0_1_0_10_10_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0_1_0_01_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,0,0,10'b0_1_0_01_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,1,0,10'b0_1_0_01_01_1_0_0));
    tv.push_back(v(0,2'b00,2'b00,0,0,0,10'b0));
    tv.push_back(v(1,2'b10,2'b10,0,0,0,10'b1_0_0_00_00_1_0_0));
    tv.push_back(v(1,2'b10,2'b10,1,0,0,10'b0_0_1_10_00_1_0_0));
    tv.push_back(v(1,2'b10,2'b10,0,1,0,10'b0_0_1_10_10_1_0_0));
    tv.push_back(v(0,2'b00,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b01,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b11,2'b00,0,0,1,10'b0_1_0_01_00_1_0_0));
    tv.push_back(v(0,2'b11,2'b00,0,1,0,10'b0_1_0_01_01_1_0_0));
    tv.push_back(v(1,2'b10,2'b00,0,0,0,10'b0));
    tv.push_back(v(0,2'b10,2'b00,0,0,0,10'b0_1_0_10_00_1_0_0));
    tv.push_back(v(0,2'b10,2'b00,0,1,0,10'b0_1_0_10_10_1_0_0));
    tv.push_back(v(1,2'b00,2'b00,0,0,0,10'b0));
    tv.push_back(v(1,2'b00,2'b00,0,0,0,10'b0_0_0_00_00_1_1_0));
    tv.push_back(v(1,2'b11,2'b11,1,1,0,10'b0_0_0_00_00_1_1_0));

    doReset();
    foreach (tv[i]) begin
      iREN = tv[i].iR; dREN = tv[i].dR; dWEN = tv[i].dW;
      ihit = tv[i].ih; dhit = tv[i].dh; halt = tv[i].hl;
      #1 check($sformatf("vec%0d", i), outv, tv[i].e);
      @(negedge CLK);
    end

    // reset dropped in the middle of a data transaction
    doReset();
    dREN = 2'b01;
    @(negedge CLK);
    #1 check("pre_reset_data", outv, 10'b0_1_0_01_00_1_0_0);
    #1;
    nRST = 0; dhit = 1; iREN = 1;
    #1 check("reset_mid_data", outv, 10'b0);
    @(negedge CLK);
    #1 check("reset_held", outv, 10'b0);
    @(negedge CLK);
    nRST = 1; dhit = 0; iREN = 0;
    #1 check("post_reset_idle", outv, 10'b0);
    @(negedge CLK);
    #1 check("post_reset_regrant", outv, 10'b0_1_0_01_00_1_0_0);
    dhit = 1;
    #1 check("post_reset_ack", outv, 10'b0_1_0_01_01_1_0_0);
    @(negedge CLK);
    idleIn();

    // watchdog: no dhit for a long time
    doReset();
    dREN = 2'b01;
    #1 check("wd_idle", outv, 10'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      #1 check($sformatf("wd_cyc%0d", k), outv,
               {9'b0_1_0_01_00_1_0, 1'(k >= 6)});
    end
    dhit = 1;
    #1 check("wd_late_ack", outv, 10'b0_1_0_01_01_1_0_1);
    @(negedge CLK);
    idleIn();
    #1 check("wd_sticky", outv, 10'b0_0_0_00_00_0_0_1);

    // random traffic against the reference model
    doReset();
    mOwner = -1; mNext = 0; mMiss = 0;
    mHp = 0; mHalted = 0; mTo = 0;
    rR = '0; rW = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic [9:0] e;
      logic [1:0] g;
      logic [1:0] rq;
      int         pick;
      bit         hpOld;
      for (int ch = 0; ch < NCH; ch++) begin
        if (!(rR[ch] | rW[ch]) && $urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(1, 3);
          rR[ch] = r[0];
          rW[ch] = r[1];
        end
      end
      dREN = rR; dWEN = rW;
      iREN = 1'($urandom_range(0, 1));
      ihit = 1'($urandom_range(0, 1));
      dhit = ($urandom_range(0, 3) == 0);
      halt = (cyc >= 450) && ($urandom_range(0, 15) == 0);
      #1;
      e = '0;
      if (mHalted) begin
        e[2] = 1; e[1] = 1;
      end else if (mOwner >= 0) begin
        g = 2'b01 << mOwner;
        e[9]   = 0;
        e[8]   = rR[mOwner] & ~rW[mOwner];
        e[7]   = rW[mOwner];
        e[6:5] = g;
        e[4:3] = dhit ? g : 2'b00;
        e[2]   = 1;
      end else begin
        e[9] = iREN & ~mHp;
        e[2] = e[9] & ~ihit;
      end
      e[0] = mTo;
      check($sformatf("rand%0d", cyc), outv, e);
      hpOld = mHp;
      if (halt) mHp = 1;
      if (mHalted) begin
      end else if (mOwner >= 0) begin
        if (mMiss >= TO) mTo = 1;
        if (dhit) begin
          rR[mOwner] = 0;
          rW[mOwner] = 0;
          mNext  = (mOwner + 1) % NCH;
          mOwner = -1;
        end else begin
          mMiss++;
        end
      end else begin
        rq   = rR | rW;
        pick = -1;
        for (int k = 0; k < NCH; k++) begin
          if (pick < 0 && rq[(mNext + k) % NCH])
            pick = (mNext + k) % NCH;
        end
        if (pick >= 0) begin
          mOwner = pick;
          mMiss  = 0;
        end else if (hpOld) begin
          mHalted = 1;
        end
      end
      @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
